// File: rtl/cond_pkg.sv
// Shared types and legal parameter bounds for the input conditioner.
package cond_pkg;

  typedef enum logic [1:0] {S_LOW, S_WAIT_HI, S_HIGH, S_WAIT_LO} cond_state_t;

  localparam int unsigned SYNC_MIN     = 2;
  localparam int unsigned SYNC_MAX     = 4;
  localparam int unsigned DEBOUNCE_MIN = 2;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous bit, async active-low reset.
module sync_chain #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stage_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// Synchronize, debounce and edge-detect one raw board input; all outputs are registered.
module input_conditioner
  import cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic clean,
  output logic rise_pulse,
  output logic fall_pulse
);

  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
    $error("input_conditioner: SYNC_STAGES out of range 2..4");
  end
  if (DEBOUNCE_CYCLES < DEBOUNCE_MIN) begin : g_bad_debounce
    $error("input_conditioner: DEBOUNCE_CYCLES must be at least 2");
  end

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q;
  cond_state_t      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             clean_q, clean_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (raw_in),
    .q    (sync_q)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      S_LOW: begin
        if (sync_q) begin
          state_d = S_WAIT_HI;
          count_d = CNT_W'(1);
        end
      end
      S_WAIT_HI: begin
        if (!sync_q) begin
          state_d = S_LOW;
          count_d = '0;
        end else if (count_q == CntLast) begin
          state_d = S_HIGH;
          count_d = '0;
          rise_d  = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!sync_q) begin
          state_d = S_WAIT_LO;
          count_d = CNT_W'(1);
        end
      end
      S_WAIT_LO: begin
        if (sync_q) begin
          state_d = S_HIGH;
          count_d = '0;
        end else if (count_q == CntLast) begin
          state_d = S_LOW;
          count_d = '0;
          fall_d  = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_LOW;
        count_d = '0;
      end
    endcase
    // Level follows the qualified state, so it is high in S_HIGH and while qualifying a fall.
    clean_d = (state_d == S_HIGH) || (state_d == S_WAIT_LO);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_LOW;
      count_q <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean      = clean_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench: vector table, corner sequences, DFF hookup and randomized model check.
module tb_input_conditioner;
  import cond_pkg::*;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic raw_in = 1'b0;
  logic clean, rise_pulse, fall_pulse;
  logic dff_q;

  int passed = 0;
  int total  = 0;

  input_conditioner #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .raw_in    (raw_in),
    .clean     (clean),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  // Lab DFF: d <- clean, enable <- rise_pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dff_q <= 1'b0;
    else if (rise_pulse) dff_q <= clean;
  end

  always #5 clk = ~clk;

  typedef struct packed {
    logic raw;
    logic rst;
    logic clean;
    logic rise;
    logic fall;
  } vec_t;

  vec_t tbl[$];

  // Reference model: clean flips once the last DEB synchronized samples all disagree with it.
  logic raw_hist[$];
  logic s_hist[$];
  logic m_clean = 1'b0;
  logic m_rise  = 1'b0;
  logic m_fall  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_edge(input logic r, input logic rst);
    logic s;
    logic flip;
    if (!rst) begin
      raw_hist.delete();
      s_hist.delete();
      m_clean = 1'b0;
      m_rise  = 1'b0;
      m_fall  = 1'b0;
    end else begin
      s = (raw_hist.size() >= SYNC) ? raw_hist[raw_hist.size() - SYNC] : 1'b0;
      raw_hist.push_back(r);
      if (raw_hist.size() > SYNC) void'(raw_hist.pop_front());
      s_hist.push_back(s);
      if (s_hist.size() > DEB) void'(s_hist.pop_front());
      flip = (s_hist.size() == DEB);
      foreach (s_hist[i]) if (s_hist[i] == m_clean) flip = 1'b0;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (flip) begin
        m_clean = ~m_clean;
        m_rise  = m_clean;
        m_fall  = ~m_clean;
      end
    end
  endtask

  // Drive inputs just after a negedge, clock once, compare at the following negedge.
  task automatic cycle(input logic r, input logic rst);
    raw_in = r;
    reset  = rst;
    @(posedge clk);
    model_edge(r, rst);
    @(negedge clk);
    chk("model_clean", int'(clean), int'(m_clean));
    chk("model_rise", int'(rise_pulse), int'(m_rise));
    chk("model_fall", int'(fall_pulse), int'(m_fall));
  endtask

  task automatic add(input logic r, input logic rs, input logic c, input logic ri, input logic f);
    vec_t v;
    v.raw = r; v.rst = rs; v.clean = c; v.rise = ri; v.fall = f;
    tbl.push_back(v);
  endtask

  initial begin
    int pulses;
    int first_rise;
    int rises;
    int falls;

    // Reset held with raw_in=1, then release and qualify.
    repeat (3) add(1, 0, 0, 0, 0);
    repeat (5) add(1, 1, 0, 0, 0);
    add(1, 1, 1, 1, 0);
    repeat (2) add(1, 1, 1, 0, 0);
    // Release: fall six edges after raw_in drops.
    repeat (5) add(0, 1, 1, 0, 0);
    add(0, 1, 0, 0, 1);
    repeat (2) add(0, 1, 0, 0, 0);
    // Bounce 1,0,1,1,0,1 then held high.
    add(1, 1, 0, 0, 0); add(0, 1, 0, 0, 0); add(1, 1, 0, 0, 0);
    add(1, 1, 0, 0, 0); add(0, 1, 0, 0, 0); add(1, 1, 0, 0, 0);
    repeat (4) add(1, 1, 0, 0, 0);
    add(1, 1, 1, 1, 0);
    add(1, 1, 1, 0, 0);

    foreach (tbl[i]) begin
      cycle(tbl[i].raw, tbl[i].rst);
      chk($sformatf("vec%0d_clean", i), int'(clean), int'(tbl[i].clean));
      chk($sformatf("vec%0d_rise", i), int'(rise_pulse), int'(tbl[i].rise));
      chk($sformatf("vec%0d_fall", i), int'(fall_pulse), int'(tbl[i].fall));
    end

    repeat (8) cycle(0, 1);
    chk("settle_low", int'(clean), 0);

    // Short glitch: three cycles high must be rejected.
    pulses = 0;
    repeat (3) begin
      cycle(1, 1);
      pulses += int'(rise_pulse) + int'(fall_pulse);
    end
    repeat (6) begin
      cycle(0, 1);
      pulses += int'(rise_pulse) + int'(fall_pulse);
    end
    chk("glitch_pulses", pulses, 0);
    chk("glitch_clean", int'(clean), 0);
    chk("glitch_state", int'(dut.state_q), int'(S_LOW));

    // Reset while qualifying a rise, then full requalification.
    repeat (4) cycle(1, 1);
    chk("mid_state", int'(dut.state_q), int'(S_WAIT_HI));
    chk("mid_count", int'(dut.count_q), 2);
    pulses = 0;
    repeat (2) begin
      cycle(1, 0);
      pulses += int'(rise_pulse) + int'(fall_pulse);
    end
    chk("mid_reset_pulses", pulses, 0);
    first_rise = 0;
    pulses = 0;
    for (int i = 1; i <= 10; i++) begin
      cycle(1, 1);
      if (rise_pulse) begin
        pulses++;
        if (first_rise == 0) first_rise = i;
      end
    end
    chk("requal_edge", first_rise, SYNC + DEB);
    chk("requal_pulses", pulses, 1);

    // DFF integration: three presses with long holds.
    repeat (3) cycle(0, 0);
    chk("dff_reset", int'(dff_q), 0);
    rises = 0;
    falls = 0;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 12; i++) begin
        cycle(1, 1);
        if (rise_pulse) begin
          rises++;
          if (p == 0) chk("dff_before_enable", int'(dff_q), 0);
        end
      end
      chk($sformatf("dff_press%0d", p), int'(dff_q), 1);
      for (int i = 0; i < 12; i++) begin
        cycle(0, 1);
        if (fall_pulse) falls++;
      end
    end
    chk("dff_rises", rises, 3);
    chk("dff_falls", falls, 3);

    // Randomized holds with occasional reset, checked against the model.
    for (int n = 0; n < 400; n++) begin
      logic v;
      int   len;
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      for (int k = 0; k < len; k++) begin
        cycle(v, ($urandom_range(0, 299) != 0));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
